// File: rtl/display_text_port.sv
// Port-mapped text-mode writer: CPU byte writes become {attr, char} display cells,
// with an auto-advancing row/column cursor, hardware newline and a clear-screen fill.
module display_text_port #(
  parameter int         COLUMNS      = 80,
  parameter int         ROWS         = 30,
  parameter int         ADDR_WIDTH   = 12,
  parameter logic [7:0] PORT_BASE    = 8'h00,
  parameter logic [7:0] DEFAULT_ATTR = 8'h07
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpuWriteStrobe,
  input  logic [7:0]            cpuPortId,
  input  logic [7:0]            cpuWriteData,
  output logic [7:0]            cpuReadData,
  output logic                  busy,
  output logic                  memWriteEnable,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [15:0]           memWriteData,
  output logic [0:0]            dbg_state
);

  localparam int CELLS = COLUMNS * ROWS;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t state, state_next;

  logic [7:0]            attr;
  logic [7:0]            col;
  logic [7:0]            row;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic                  char_we;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [15:0]           data_r;

  logic [7:0]            offset;
  logic                  in_window;
  logic                  accept;
  logic                  wr_char, wr_attr, wr_col, wr_row, wr_cmd;
  logic                  start_clear, newline;
  logic                  fill_last;
  logic                  last_col, last_row;
  logic [7:0]            adv_col, adv_row, nl_row;
  logic [ADDR_WIDTH-1:0] cur_addr;

  // Window decode by offset from the base keeps the compare 8 bits wide.
  assign offset      = cpuPortId - PORT_BASE;
  assign in_window   = (offset <= 8'd4);
  assign accept      = cpuWriteStrobe && in_window && (state == IDLE);
  assign wr_char     = accept && (offset == 8'd0);
  assign wr_attr     = accept && (offset == 8'd1);
  assign wr_col      = accept && (offset == 8'd2);
  assign wr_row      = accept && (offset == 8'd3);
  assign wr_cmd      = accept && (offset == 8'd4);
  assign start_clear = wr_cmd && (cpuWriteData == 8'h01);
  assign newline     = wr_cmd && (cpuWriteData == 8'h02);

  assign fill_last = (fill_cnt == ADDR_WIDTH'(CELLS - 1));
  assign last_col  = (col == 8'(COLUMNS - 1));
  assign last_row  = (row == 8'(ROWS - 1));
  assign nl_row    = last_row ? 8'd0 : row + 8'd1;
  assign adv_col   = last_col ? 8'd0 : col + 8'd1;
  assign adv_row   = last_col ? nl_row : row;
  assign cur_addr  = ADDR_WIDTH'(int'(row) * COLUMNS + int'(col));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_clear) state_next = CLEAR;
      CLEAR:   if (fill_last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      attr     <= DEFAULT_ATTR;
      col      <= 8'd0;
      row      <= 8'd0;
      fill_cnt <= '0;
      char_we  <= 1'b0;
      addr_r   <= '0;
      data_r   <= 16'h0000;
    end else begin
      char_we <= wr_char;
      if (wr_char) begin
        addr_r <= cur_addr;
        data_r <= {attr, cpuWriteData};
        col    <= adv_col;
        row    <= adv_row;
      end
      if (wr_attr) attr <= cpuWriteData;
      if (wr_col)  col  <= (int'(cpuWriteData) < COLUMNS) ? cpuWriteData : 8'd0;
      if (wr_row)  row  <= (int'(cpuWriteData) < ROWS)    ? cpuWriteData : 8'd0;
      if (newline) begin
        col <= 8'd0;
        row <= nl_row;
      end
      if (start_clear) fill_cnt <= '0;
      // Mirror each fill write into the hold registers so outputs keep the last cell afterwards.
      if (state == CLEAR) begin
        addr_r   <= fill_cnt;
        data_r   <= {attr, 8'h20};
        fill_cnt <= fill_cnt + 1'b1;
        if (fill_last) begin
          col <= 8'd0;
          row <= 8'd0;
        end
      end
    end
  end

  assign busy           = (state == CLEAR);
  assign memWriteEnable = busy || char_we;
  assign memAddress     = busy ? fill_cnt : addr_r;
  assign memWriteData   = busy ? {attr, 8'h20} : data_r;
  assign dbg_state      = state;

  always_comb begin
    cpuReadData = 8'h00;
    case (offset)
      8'd1:    cpuReadData = attr;
      8'd2:    cpuReadData = col;
      8'd3:    cpuReadData = row;
      8'd4:    cpuReadData = {7'b0, busy};
      default: cpuReadData = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_display_text_port.sv
// Directed bench for display_text_port on a 4x2 screen with the register window at 8'h10.
module tb_display_text_port;

  localparam int         COLS = 4;
  localparam int         RWS  = 2;
  localparam int         AW   = 4;
  localparam logic [7:0] BASE = 8'h10;

  logic          clk;
  logic          reset;
  logic          cpuWriteStrobe;
  logic [7:0]    cpuPortId;
  logic [7:0]    cpuWriteData;
  logic [7:0]    cpuReadData;
  logic          busy;
  logic          memWriteEnable;
  logic [AW-1:0] memAddress;
  logic [15:0]   memWriteData;
  logic [0:0]    dbg_state;

  int checks;
  int failures;

  display_text_port #(
    .COLUMNS(COLS), .ROWS(RWS), .ADDR_WIDTH(AW), .PORT_BASE(BASE), .DEFAULT_ATTR(8'h07)
  ) dut (
    .clk(clk), .reset(reset), .cpuWriteStrobe(cpuWriteStrobe), .cpuPortId(cpuPortId),
    .cpuWriteData(cpuWriteData), .cpuReadData(cpuReadData), .busy(busy),
    .memWriteEnable(memWriteEnable), .memAddress(memAddress), .memWriteData(memWriteData),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change on negedge, outputs checked on negedge
  task automatic cpu_write(input logic [7:0] port, input logic [7:0] data);
    @(negedge clk);
    cpuWriteStrobe = 1'b1;
    cpuPortId      = port;
    cpuWriteData   = data;
    @(negedge clk);
    cpuWriteStrobe = 1'b0;
  endtask

  task automatic read_port(input logic [7:0] port, output logic [7:0] data);
    cpuPortId = port;
    #1;
    data = cpuReadData;
  endtask

  task automatic test_reset;
    logic [7:0] rd;
    reset = 1'b0;
    cpuWriteStrobe = 1'b0;
    cpuPortId = 8'h00;
    cpuWriteData = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (memWriteEnable !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", memWriteEnable); end
    checks++; if (memAddress !== 4'h0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", memAddress); end
    checks++; if (memWriteData !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", memWriteData); end
    checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
    reset = 1'b1;
    read_port(BASE + 8'd1, rd);
    checks++; if (rd !== 8'h07) begin failures++; $display("FAIL reset_attr got=%h exp=07", rd); end
    read_port(BASE + 8'd2, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL reset_col got=%h exp=00", rd); end
    read_port(BASE + 8'd3, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL reset_row got=%h exp=00", rd); end
  endtask

  task automatic test_first_char;
    logic [7:0] rd;
    cpu_write(BASE, 8'h48);
    checks++; if (memWriteEnable !== 1'b1) begin failures++; $display("FAIL char_we got=%b exp=1", memWriteEnable); end
    checks++; if (memAddress !== 4'h0) begin failures++; $display("FAIL char_addr got=%0h exp=0", memAddress); end
    checks++; if (memWriteData !== 16'h0748) begin failures++; $display("FAIL char_data got=%h exp=0748", memWriteData); end
    @(negedge clk);
    checks++; if (memWriteEnable !== 1'b0) begin failures++; $display("FAIL char_we_pulse got=%b exp=0", memWriteEnable); end
    checks++; if (memWriteData !== 16'h0748) begin failures++; $display("FAIL char_hold got=%h exp=0748", memWriteData); end
    read_port(BASE + 8'd2, rd);
    checks++; if (rd !== 8'h01) begin failures++; $display("FAIL char_col got=%h exp=01", rd); end
  endtask

  task automatic test_wrap;
    logic [7:0] rd;
    cpu_write(BASE + 8'd2, 8'd0);
    for (int i = 0; i < 8; i++) begin
      cpu_write(BASE, 8'h41 + 8'(i));
      checks++;
      if (memWriteEnable !== 1'b1 || memAddress !== 4'(i) || memWriteData !== {8'h07, 8'h41 + 8'(i)}) begin
        failures++;
        $display("FAIL wrap_write%0d got we=%b addr=%0h data=%h exp we=1 addr=%0h data=%h",
                 i, memWriteEnable, memAddress, memWriteData, i, {8'h07, 8'h41 + 8'(i)});
      end
    end
    read_port(BASE + 8'd2, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL wrap_col got=%h exp=00", rd); end
    read_port(BASE + 8'd3, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL wrap_row got=%h exp=00", rd); end
  endtask

  task automatic test_position;
    logic [7:0] rd;
    cpu_write(BASE + 8'd1, 8'h1E);
    cpu_write(BASE + 8'd2, 8'd3);
    cpu_write(BASE + 8'd3, 8'd1);
    read_port(BASE + 8'd1, rd);
    checks++; if (rd !== 8'h1E) begin failures++; $display("FAIL pos_attr got=%h exp=1e", rd); end
    cpu_write(BASE, 8'h5A);
    checks++; if (memAddress !== 4'd7) begin failures++; $display("FAIL pos_addr got=%0h exp=7", memAddress); end
    checks++; if (memWriteData !== 16'h1E5A) begin failures++; $display("FAIL pos_data got=%h exp=1e5a", memWriteData); end
    read_port(BASE + 8'd2, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL pos_col_wrap got=%h exp=00", rd); end
    read_port(BASE + 8'd3, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL pos_row_wrap got=%h exp=00", rd); end
    cpu_write(BASE + 8'd2, 8'd9);
    read_port(BASE + 8'd2, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL col_oob got=%h exp=00", rd); end
    cpu_write(BASE + 8'd3, 8'd2);
    read_port(BASE + 8'd3, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL row_oob got=%h exp=00", rd); end
    read_port(BASE + 8'd5, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL unmapped_read got=%h exp=00", rd); end
    cpu_write(BASE + 8'd1, 8'h07);
  endtask

  task automatic test_newline;
    logic [7:0] rd;
    cpu_write(BASE + 8'd2, 8'd2);
    cpu_write(BASE + 8'd4, 8'h55);
    read_port(BASE + 8'd2, rd);
    checks++; if (rd !== 8'h02) begin failures++; $display("FAIL cmd_ignored got=%h exp=02", rd); end
    cpu_write(BASE + 8'd4, 8'h02);
    read_port(BASE + 8'd3, rd);
    checks++; if (rd !== 8'h01) begin failures++; $display("FAIL nl_row_inc got=%h exp=01", rd); end
    cpu_write(BASE + 8'd2, 8'd2);
    cpu_write(BASE + 8'd4, 8'h02);
    checks++; if (memWriteEnable !== 1'b0) begin failures++; $display("FAIL nl_no_write got=%b exp=0", memWriteEnable); end
    read_port(BASE + 8'd2, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL nl_col got=%h exp=00", rd); end
    read_port(BASE + 8'd3, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL nl_row_wrap got=%h exp=00", rd); end
  endtask

  task automatic test_clear;
    logic [7:0] rd;
    logic [AW-1:0] exp_q[$];
    for (int i = 0; i < COLS * RWS; i++) exp_q.push_back(AW'(i));
    cpu_write(BASE + 8'd2, 8'd1);
    cpu_write(BASE + 8'd3, 8'd1);
    cpu_write(BASE + 8'd4, 8'h01);
    for (int i = 0; i < COLS * RWS; i++) begin
      checks++;
      if (busy !== 1'b1 || memWriteEnable !== 1'b1 || memAddress !== exp_q[0] || memWriteData !== 16'h0720) begin
        failures++;
        $display("FAIL clear_cycle%0d got busy=%b we=%b addr=%0h data=%h exp busy=1 we=1 addr=%0h data=0720",
                 i, busy, memWriteEnable, memAddress, memWriteData, exp_q[0]);
      end
      void'(exp_q.pop_front());
      if (i == 3) begin
        cpuWriteStrobe = 1'b1;
        cpuPortId      = BASE;
        cpuWriteData   = 8'h99;
      end
      if (i == 4) cpuWriteStrobe = 1'b0;
      if (i == 5) begin
        read_port(BASE + 8'd4, rd);
        checks++; if (rd !== 8'h01) begin failures++; $display("FAIL clear_busy_read got=%h exp=01", rd); end
      end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_done_busy got=%b exp=0", busy); end
    checks++; if (memWriteEnable !== 1'b0) begin failures++; $display("FAIL clear_done_we got=%b exp=0", memWriteEnable); end
    checks++; if (memAddress !== 4'd7) begin failures++; $display("FAIL clear_hold_addr got=%0h exp=7", memAddress); end
    read_port(BASE + 8'd2, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL clear_col got=%h exp=00", rd); end
    read_port(BASE + 8'd3, rd);
    checks++; if (rd !== 8'h00) begin failures++; $display("FAIL clear_row got=%h exp=00", rd); end
    cpu_write(BASE, 8'h21);
    checks++; if (memAddress !== 4'd0 || memWriteData !== 16'h0721) begin
      failures++; $display("FAIL clear_drop got addr=%0h data=%h exp addr=0 data=0721", memAddress, memWriteData);
    end
  endtask

  task automatic test_reset_in_clear;
    logic [7:0] rd;
    int stray;
    cpu_write(BASE + 8'd1, 8'h1E);
    cpu_write(BASE + 8'd4, 8'h01);
    @(negedge clk);
    @(negedge clk);
    checks++; if (memAddress !== 4'd2) begin failures++; $display("FAIL rst_clear_cycle3 got=%0h exp=2", memAddress); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_clear_busy got=%b exp=0", busy); end
    checks++; if (memWriteEnable !== 1'b0) begin failures++; $display("FAIL rst_clear_we got=%b exp=0", memWriteEnable); end
    read_port(BASE + 8'd1, rd);
    checks++; if (rd !== 8'h07) begin failures++; $display("FAIL rst_clear_attr got=%h exp=07", rd); end
    @(negedge clk);
    reset = 1'b1;
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (memWriteEnable !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL rst_clear_stray got=%0d exp=0", stray); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_first_char();
    test_wrap();
    test_position();
    test_newline();
    test_clear();
    test_reset_in_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_text_port.md
Name: display_text_port

Overview:
- Port-mapped text-mode writer. Sits between the CPU I/O bus (write strobe, port id, write data) and the text display memory.
- Turns byte-wide CPU port writes into 16-bit character cells: attribute in the high byte, character code in the low byte.
- Keeps a row/column cursor that auto-advances and wraps. Supports hardware newline and a multi-cycle clear-screen fill.
- Parametrised in screen geometry and port base, so it replaces hand-coded per-cell memory writes in display designs.

Parameters:
- COLUMNS, 80, characters per row (1..255)
- ROWS, 30, rows per screen (1..255)
- ADDR_WIDTH, 12, width of memAddress; 2^ADDR_WIDTH >= COLUMNS*ROWS
- PORT_BASE, 8'h00, first CPU port id of the 5-port register window
- DEFAULT_ATTR, 8'h07, attribute register value after reset

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- cpuWriteStrobe  in  1  CPU port write qualifier
- cpuPortId  in  8  CPU port address
- cpuWriteData  in  8  CPU port write data
- cpuReadData  out  8  combinational readback for the current cpuPortId
- busy  out  1  high while the clear fill runs
- memWriteEnable  out  1  display memory write enable, one cycle per cell
- memAddress  out  ADDR_WIDTH  cell address = row*COLUMNS + col
- memWriteData  out  16  {attr, char}

Behaviour:
- Reset: sampled only on a rising clk edge with reset=0. Values after reset:
  - state IDLE, attr=DEFAULT_ATTR, col=0, row=0
  - busy=0, memWriteEnable=0, memAddress=0, memWriteData=0
  - reset during CLEAR aborts the fill immediately; no further writes are issued.
- Register window: a write is accepted when cpuWriteStrobe=1, cpuPortId is in PORT_BASE..PORT_BASE+4, and state is IDLE. Writes while busy=1 are dropped silently.
  - +0 CHAR: memory write of {attr, data} at the current cursor, then the cursor advances.
  - +1 ATTR: attr := data.
  - +2 COL: col := data if data < COLUMNS, else col := 0.
  - +3 ROW: row := data if data < ROWS, else row := 0.
  - +4 CMD: 8'h01 starts CLEAR; 8'h02 is NEWLINE; any other value is ignored.
- CHAR timing: strobe at edge t gives memWriteEnable=1 for exactly the cycle after t, with the address of the cursor before the advance.
- Cursor advance:
  - if col < COLUMNS-1: col+1
  - else col := 0 and row := row+1; row wraps ROWS-1 -> 0.
- NEWLINE: col := 0 and row := row+1 with the same wrap; no memory write.
- CLEAR state machine (IDLE -> CLEAR -> IDLE):
  - on accepting the command, the fill counter := 0 and state := CLEAR.
  - each CLEAR cycle drives memWriteEnable=1, memAddress=counter, memWriteData={attr, 8'h20}, then increments the counter.
  - busy=1 in exactly the N=COLUMNS*ROWS cycles where those writes occur.
  - after address N-1: state := IDLE, col := 0, row := 0, busy falls on the next cycle.
- memWriteEnable is 0 in every cycle not listed above. memAddress and memWriteData hold their last values when memWriteEnable=0.
- cpuReadData (combinational, not gated by the strobe):
  - +1 attr, +2 col, +3 row, +4 {7'b0, busy}, any other port 8'h00.
- Address arithmetic is unsigned and truncated to ADDR_WIDTH. The parameter constraint guarantees no overflow.

Test Plan:
- Release reset after 3 cycles, write port +0 with 8'h48 -> next cycle memWriteEnable=1, memAddress=0, memWriteData=16'h0748; col=1.
- COLUMNS=4, ROWS=2: eight CHAR writes 8'h41..8'h48 -> addresses 0..7 in order; after the 8th write col=0, row=0 (full wrap).
- ATTR=8'h1E, COL=3, ROW=1, CHAR 8'h5A (COLUMNS=4) -> memAddress=7, data 16'h1E5A, then col=0, row=0. COL=9 -> readback of port +2 is 8'h00.
- CMD 8'h01 with COLUMNS=4, ROWS=2, attr=8'h07 -> busy=1 for 8 consecutive cycles, writes 16'h0720 to addresses 0..7, then busy=0 and cursor at 0,0. A CHAR write issued mid-fill is dropped.
- NEWLINE at row=ROWS-1, col=2 -> row=0, col=0, no memWriteEnable pulse.
- Pull reset low on the 3rd CLEAR cycle -> from the next edge on, busy=0, memWriteEnable=0, attr=8'h07, no further writes after reset is released.
